// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, default sizes and log2 helper for the matmul sequencer
package matmul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int N_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int MAC_LAT_DEF = 1;
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/matmul_seq_tag_pipe.sv
// tag_pipe: fixed-depth shift register with asynchronous clear for term tags
module tag_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : s
    always_ff @(posedge clk or posedge rst)
      if (rst) r[g] <= '0;
      else r[g] <= (g == 0) ? d : r[(g == 0) ? 0 : g - 1];
  end
  assign q = r[DEPTH-1];
endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: walks (row, col, k) for a shared-MAC NxN matrix multiply and schedules RAM reads, MAC strobes and C writes
module matmul_seq import matmul_pkg::*; #(
  parameter int N = N_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int AW = 2 * log2(N),
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] clock_count,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          c_we,
  output logic [AW-1:0] c_addr
);
  localparam int LW = AW / 2;
  state_t state, nxt;
  logic [LW-1:0] row, col, k;
  logic [AW+2:0] p1_d, p1_q;
  logic [AW:0] p2_d, p2_q;
  logic [AW-1:0] c_hold;
  logic start_acc, last_term, fin;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign rd_en = state == RUN && !pause;
  assign a_addr = {row, k};
  assign b_addr = {col, k};
  assign start_acc = start && (state == IDLE || state == DONE);
  assign last_term = rd_en && &{row, col, k};
  assign p1_d = {rd_en, k == '0, &k, row, col};
  assign mac_en = p1_q[AW+2];
  assign mac_clear = mac_en && p1_q[AW+1];
  assign p2_d = {mac_en && p1_q[AW], p1_q[AW-1:0]};
  assign c_we = p2_q[AW];
  // c_addr keeps the last written address between writes
  assign c_addr = c_we ? p2_q[AW-1:0] : c_hold;
  tag_pipe #(.DEPTH(RD_LAT), .W(AW + 3)) u_issue (.clk, .rst, .d(p1_d), .q(p1_q));
  tag_pipe #(.DEPTH(MAC_LAT), .W(AW + 1)) u_mac (.clk, .rst, .d(p2_d), .q(p2_q));
  always_comb begin
    nxt = state;
    if (start_acc) nxt = RUN;
    else if (state == RUN && last_term) nxt = DRAIN;
    else if (state == DRAIN && fin) nxt = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      k <= '0;
      clock_count <= '0;
      fin <= 1'b0;
      c_hold <= '0;
    end else begin
      state <= nxt;
      fin <= c_we && &p2_q[AW-1:0];
      if (c_we) c_hold <= p2_q[AW-1:0];
      if (start_acc) begin
        row <= '0;
        col <= '0;
        k <= '0;
        clock_count <= '0;
      end else begin
        if (busy && clock_count != '1) clock_count <= clock_count + 1'b1;
        if (rd_en) begin
          k <= k + 1'b1;
          if (&k) begin
            col <= col + 1'b1;
            if (&col) row <= row + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed checks of the matmul sequencer at default size and at N=2 with deeper latencies
module tb_matmul_seq;
  logic clk = 0, rst = 0, start = 0, pause = 0;
  logic busy, done, rd_en, mac_clear, mac_en, c_we;
  logic [10:0] clock_count;
  logic [5:0] a_addr, b_addr, c_addr;
  logic s_start = 0, s_busy, s_done, s_rd_en, s_mac_clear, s_mac_en, s_c_we;
  logic [10:0] s_clock_count;
  logic [1:0] s_a_addr, s_b_addr, s_c_addr;
  int checks = 0, failures = 0;
  int nterms, nwr, nmac, bad_term, bad_wr, bad_clr, first_rd, last_rd;
  logic [5:0] a0, b0, a1, b1, a8, b8;
  logic clr8;

  matmul_seq dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
    .clock_count(clock_count), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .mac_clear(mac_clear), .mac_en(mac_en), .c_we(c_we), .c_addr(c_addr)
  );

  matmul_seq #(.N(2), .RD_LAT(2), .MAC_LAT(2), .AW(2), .CW(11)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .pause(1'b0), .busy(s_busy), .done(s_done),
    .clock_count(s_clock_count), .rd_en(s_rd_en), .a_addr(s_a_addr), .b_addr(s_b_addr),
    .mac_clear(s_mac_clear), .mac_en(s_mac_en), .c_we(s_c_we), .c_addr(s_c_addr)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #2 rst = 1;
    #2;
    checks++;
    if ({busy, done, rd_en, mac_clear, mac_en, c_we, a_addr, b_addr, c_addr, clock_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b cnt=%0d want all 0", busy, done, rd_en, clock_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, clock_count} !== '0) begin
      failures++;
      $display("FAIL idle_hold got busy=%b done=%b rd_en=%b cnt=%0d want 0", busy, done, rd_en, clock_count);
    end
  endtask

  task automatic run_def(input int p_at, input int p_len, input int poke_at, input int exp_cnt, input string nm);
    int cyc = 0, pc = 0;
    nterms = 0; nwr = 0; nmac = 0; bad_term = 0; bad_wr = 0; bad_clr = 0; first_rd = -1; last_rd = -1;
    start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (done !== 1'b0 || clock_count !== 11'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept got done=%b busy=%b cnt=%0d want done=0 busy=1 cnt=0", nm, done, busy, clock_count);
    end
    while (done !== 1'b1 && cyc < 3000) begin
      pause = p_len > 0 && nterms == p_at && pc < p_len;
      if (pause) pc++;
      start = (cyc == poke_at);
      #1;
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (a_addr !== 6'((nterms / 64) * 8 + nterms % 8) || b_addr !== 6'(((nterms / 8) % 8) * 8 + nterms % 8)) bad_term++;
        if (nterms == 0) begin a0 = a_addr; b0 = b_addr; end
        if (nterms == 1) begin a1 = a_addr; b1 = b_addr; end
        if (nterms == 8) begin a8 = a_addr; b8 = b_addr; end
        nterms++;
      end
      if (mac_en) begin
        if (mac_clear !== (nmac % 8 == 0)) bad_clr++;
        if (nmac == 8) clr8 = mac_clear;
        nmac++;
      end
      if (c_we) begin
        if (c_addr !== 6'(nwr)) bad_wr++;
        nwr++;
      end
      @(negedge clk);
      cyc++;
    end
    pause = 0;
    start = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done got done=%b busy=%b after %0d cycles want done=1 busy=0", nm, done, busy, cyc);
    end
    checks++;
    if (clock_count !== 11'(exp_cnt)) begin
      failures++;
      $display("FAIL %s_count got %0d want %0d", nm, clock_count, exp_cnt);
    end
    checks++;
    if (nterms != 512 || last_rd - first_rd + 1 != 512 + p_len) begin
      failures++;
      $display("FAIL %s_terms got %0d terms over %0d cycles want 512 over %0d", nm, nterms, last_rd - first_rd + 1, 512 + p_len);
    end
    checks++;
    if (bad_term != 0) begin
      failures++;
      $display("FAIL %s_addr_seq got %0d bad terms want 0", nm, bad_term);
    end
    checks++;
    if ({a0, b0, a1, b1, a8, b8} !== {6'd0, 6'd0, 6'd1, 6'd1, 6'd0, 6'd8}) begin
      failures++;
      $display("FAIL %s_first_terms got a0=%0d b0=%0d a1=%0d b1=%0d a8=%0d b8=%0d want 0 0 1 1 0 8", nm, a0, b0, a1, b1, a8, b8);
    end
    checks++;
    if (nmac != 512 || bad_clr != 0 || clr8 !== 1'b1) begin
      failures++;
      $display("FAIL %s_mac got %0d mac_en, %0d bad clears, term9 clear=%b want 512, 0, 1", nm, nmac, bad_clr, clr8);
    end
    checks++;
    if (nwr != 64 || bad_wr != 0) begin
      failures++;
      $display("FAIL %s_writes got %0d writes, %0d out of order want 64, 0", nm, nwr, bad_wr);
    end
  endtask

  task automatic test_full_run;
    run_def(-1, 0, -1, 515, "full");
  endtask

  task automatic test_done_hold;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || clock_count !== 11'd515 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL done_hold got done=%b cnt=%0d rd_en=%b want 1 515 0", done, clock_count, rd_en);
    end
  endtask

  task automatic test_pause;
    run_def(100, 10, -1, 525, "pause");
  endtask

  task automatic test_start_ignored;
    run_def(-1, 0, 50, 515, "restart");
  endtask

  task automatic test_reset_mid_run;
    int n = 0, cyc = 0, bad = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (n < 200 && cyc < 1000) begin
      #1;
      if (rd_en) n++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (n != 200) begin
      failures++;
      $display("FAIL midrst_reach got %0d terms want 200", n);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, done, rd_en, mac_clear, mac_en, c_we, a_addr, b_addr, c_addr, clock_count} !== '0) begin
      failures++;
      $display("FAIL midrst_async got busy=%b rd_en=%b mac_en=%b c_we=%b cnt=%0d want all 0", busy, rd_en, mac_en, c_we, clock_count);
    end
    @(negedge clk);
    rst = 0;
    repeat (20) begin
      #1;
      if (mac_en || c_we || busy || rd_en) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_quiet got %0d active cycles want 0", bad);
    end
    run_def(-1, 0, -1, 515, "after_rst");
  endtask

  task automatic test_small;
    int ea[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int eb[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int nt = 0, nw = 0, bad = 0, cyc = 0;
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    while (s_done !== 1'b1 && cyc < 100) begin
      #1;
      if (s_rd_en) begin
        if (nt < 8 && (s_a_addr !== 2'(ea[nt]) || s_b_addr !== 2'(eb[nt]))) bad++;
        nt++;
      end
      if (s_c_we) begin
        if (s_c_addr !== 2'(nw)) bad++;
        nw++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (nt != 8 || nw != 4 || bad != 0) begin
      failures++;
      $display("FAIL small_seq got %0d terms %0d writes %0d bad want 8 4 0", nt, nw, bad);
    end
    checks++;
    if (s_done !== 1'b1 || s_clock_count !== 11'd13) begin
      failures++;
      $display("FAIL small_count got done=%b cnt=%0d want 1 13", s_done, s_clock_count);
    end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_done_hold;
    test_pause;
    test_start_ignored;
    test_reset_mid_run;
    test_small;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
